instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory reader feeding a 2-entry
// {pc, instr} queue to decode, with redirect flush and drain of stale responses.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        in_ready
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pending_pc;
  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [31:0] r_pc_q    [2];
  logic [31:0] r_instr_q [2];

  logic [31:0] w_redir_pc;
  logic        w_done;
  logic        w_push;
  logic        w_pop;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

  // Requests stay up in DRAIN; in FETCH the queue only fills via acked
  // requests, so a raised request cannot be withdrawn before its ack.
  assign mem_req  = !reset && ((r_state == DRAIN) || (r_count != 2'd2));
  assign mem_addr = r_fetch_pc;

  assign w_done = mem_req && mem_ack;
  assign w_push = (r_state == FETCH) && w_done && !redirect_valid;
  assign w_pop  = out_valid && in_ready && !redirect_valid;

  assign out_valid = (r_count != 2'd0);
  assign out_pc    = r_pc_q[r_rd_ptr];
  assign out_instr = r_instr_q[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_fetch_pc   <= RESET_PC_AL;
      r_pending_pc <= 32'h0;
    end else begin
      case (r_state)
        FETCH: begin
          if (redirect_valid) begin
            if (mem_req && !mem_ack) begin
              r_pending_pc <= w_redir_pc;
              r_state      <= DRAIN;
            end else begin
              r_fetch_pc <= w_redir_pc;
            end
          end else if (w_done) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        DRAIN: begin
          if (w_done) begin
            r_fetch_pc <= redirect_valid ? w_redir_pc : r_pending_pc;
            r_state    <= FETCH;
          end else if (redirect_valid) begin
            r_pending_pc <= w_redir_pc;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= 2'd0;
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_pc_q[0]    <= 32'h0;
      r_pc_q[1]    <= 32'h0;
      r_instr_q[0] <= 32'h0;
      r_instr_q[1] <= 32'h0;
    end else if (redirect_valid) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_pc_q[r_wr_ptr]    <= r_fetch_pc;
        r_instr_q[r_wr_ptr] <= mem_rdata;
        r_wr_ptr            <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: per-cycle vector table with expected request and
// output state, plus a queue scoreboard of delivered {pc, instr} in order.
module tb_instr_fetch_unit;

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic        keep;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        in_ready = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb[$];
  vec_t        tbl[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] f_data(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign mem_rdata = f_data(mem_addr);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .in_ready(in_ready)
  );

  function automatic vec_t mk(input logic ack, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic e_req,
                              input logic [31:0] e_addr, input logic e_ov,
                              input logic [31:0] e_pc, input logic keep);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.keep = keep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    logic [31:0] e;
    @(posedge clk);
    #1;
    mem_ack = v.ack; in_ready = v.rdy; redirect_valid = v.rv; redirect_pc = v.rpc;
    @(negedge clk);
    chk({tag, "_req"}, 32'(mem_req), 32'(v.e_req));
    chk({tag, "_addr"}, mem_addr, v.e_addr);
    chk({tag, "_ov"}, 32'(out_valid), 32'(v.e_ov));
    if (v.e_ov) begin
      chk({tag, "_pc"}, out_pc, v.e_pc);
      chk({tag, "_instr"}, out_instr, f_data(v.e_pc));
    end
    if (v.rv) begin
      sb.delete();
    end else begin
      if (out_valid && in_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s_sb: got pc %h expected no output", tag, out_pc);
        end else begin
          e = sb.pop_front();
          chk({tag, "_sb_pc"}, out_pc, e);
          chk({tag, "_sb_instr"}, out_instr, f_data(e));
        end
      end
      if (v.keep) sb.push_back(v.e_addr);
    end
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_ov"}, 32'(out_valid), 32'h0);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_instr"}, out_instr, 32'h0);
  endtask

  // Release at a falling edge so the first post-reset cycle is observable.
  task automatic release_reset(input string tag);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; in_ready = 1'b1; redirect_valid = 1'b0;
    #1;
    chk({tag, "_req"}, 32'(mem_req), 32'h1);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_ov"}, 32'(out_valid), 32'h0);
    sb.delete();
    sb.push_back(32'h0);
  endtask

  initial begin
    //             ack rdy rv rpc            req addr          ov pc            keep
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h4,        1, 32'h0,        1));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h8,        1, 32'h4,        1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'hC,        1, 32'h8,        1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 0, 32'h0,      0, 32'h10,       1, 32'h8,        0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h10,       1, 32'h8,        0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h10,       1, 32'hC,        1));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h14,       1, 32'h10,       1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'h18,       1, 32'h14,       1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h1C,       1, 32'h14,       0));
    tbl.push_back(mk(0, 1, 1, 32'h1003,     0, 32'h1C,       1, 32'h14,       0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h1000,     0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h1000,     0, 32'h0,        1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h1004,     1, 32'h1000,     0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h1004,     0, 32'h0,        0));
    tbl.push_back(mk(0, 1, 1, 32'h40,       1, 32'h1004,     0, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h1004,     0, 32'h0,        0));
    tbl.push_back(mk(0, 1, 1, 32'h80,       1, 32'h1004,     0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h1004,     0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h80,       0, 32'h0,        1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h84,       1, 32'h80,       0));
    tbl.push_back(mk(0, 1, 1, 32'h200,      1, 32'h84,       0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 1, 32'h300,      1, 32'h84,       0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h300,      0, 32'h0,        1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h304,      1, 32'h300,      0));
    tbl.push_back(mk(1, 1, 1, 32'h503,      1, 32'h304,      0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h500,      0, 32'h0,        1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h504,      1, 32'h500,      0));
    tbl.push_back(mk(1, 1, 1, 32'hFFFF_FFFF, 1, 32'h504,     0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,       1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFC, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_in_reset("rst0");
    release_reset("rel0");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("c%0d", i + 1));

    // Asynchronous reset mid-cycle with a request to 0x4 outstanding.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_in_reset("rst1");
    @(posedge clk);
    #1;
    check_in_reset("rst1_hold");
    release_reset("rel1");
    step(mk(1, 1, 0, 32'h0, 1, 32'h4, 1, 32'h0, 1), "p1");
    step(mk(0, 1, 0, 32'h0, 1, 32'h8, 1, 32'h4, 0), "p2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
